// File: rtl/dmem_resp.sv
// Data-memory response block: posted-store write buffer in front of a single-port SRAM.
// Define DMEM_FWD_EN to forward load hits out of the write buffer instead of stalling.
module dmem_resp #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       d_mem_w_addr,
  input  logic [31:0]       d_mem_w_data,
  input  logic              d_mem_we,
  input  logic              d_mem_oe,
  output logic [31:0]       d_mem_r_data,
  output logic              d_mem_rvalid,
  output logic              d_mem_stall,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              buf_empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [ADDR_W-1:0] buf_addr_q [DEPTH];
  logic [31:0]       buf_data_q [DEPTH];

  logic [ADDR_W-1:0] req_waddr;
  logic              is_store, is_load, full;
  logic              enq, pop, port_busy;
  logic              hit;
  logic [PtrW-1:0]   idx;
`ifdef DMEM_FWD_EN
  logic [31:0]       hit_data;
`endif

  logic unused_addr;
  assign unused_addr = ^{d_mem_w_addr[31:ADDR_W+2], d_mem_w_addr[1:0]};

  assign req_waddr = d_mem_w_addr[ADDR_W+1:2];
  assign is_store  = d_mem_we;
  assign is_load   = d_mem_oe & ~d_mem_we;
  assign full      = (count_q == CntW'(DEPTH));
  assign buf_empty = (count_q == '0);

  // Walk entries oldest to newest so the last match wins (newest data).
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef DMEM_FWD_EN
    hit_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (buf_addr_q[idx] == req_waddr)) begin
        hit = 1'b1;
`ifdef DMEM_FWD_EN
        hit_data = buf_data_q[idx];
`endif
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    d_mem_stall  = 1'b0;
    d_mem_rvalid = 1'b0;
    d_mem_r_data = '0;
    sram_en      = 1'b0;
    sram_we      = 1'b0;
    sram_addr    = '0;
    sram_wdata   = '0;
    enq          = 1'b0;
    port_busy    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_store) begin
          if (full) d_mem_stall = 1'b1;
          else      enq         = 1'b1;
        end else if (is_load) begin
`ifdef DMEM_FWD_EN
          if (hit) begin
            d_mem_rvalid = 1'b1;
            d_mem_r_data = hit_data;
          end else begin
`else
          if (hit) begin
            // Let the drain retire the matching stores before reading SRAM.
            d_mem_stall = 1'b1;
          end else begin
`endif
            sram_en     = 1'b1;
            sram_addr   = req_waddr;
            d_mem_stall = 1'b1;
            port_busy   = 1'b1;
            state_d     = StRdWait;
          end
        end
      end
      StRdWait: begin
        d_mem_rvalid = 1'b1;
        d_mem_r_data = sram_rdata;
        d_mem_stall  = is_store;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Stores accumulate while the core keeps issuing them; the buffer drains in gaps.
    pop = ~buf_empty & ~port_busy & ~enq;
    if (pop) begin
      sram_en    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = buf_addr_q[rd_ptr_q];
      sram_wdata = buf_data_q[rd_ptr_q];
    end

    if (!rst) begin
      d_mem_stall  = 1'b0;
      d_mem_rvalid = 1'b0;
      d_mem_r_data = '0;
      sram_en      = 1'b0;
      sram_we      = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({enq, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      buf_addr_q[wr_ptr_q] <= req_waddr;
      buf_data_q[wr_ptr_q] <= d_mem_w_data;
    end
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 4, write-buffer entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 10, SRAM word-address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port d_mem_w_addr, input, 32, byte address for both loads and stores; bits [ADDR_W+1:2] used, others ignored.
REQ-006 SHALL have port d_mem_w_data, input, 32, store data.
REQ-007 SHALL have port d_mem_we, input, 1, store request.
REQ-008 SHALL have port d_mem_oe, input, 1, load request.
REQ-009 SHALL have port d_mem_r_data, output, 32, load data.
REQ-010 SHALL have port d_mem_rvalid, output, 1, d_mem_r_data valid this cycle.
REQ-011 SHALL have port d_mem_stall, output, 1, request not accepted; the core holds the request unchanged.
REQ-012 SHALL have ports sram_en (1), sram_we (1), sram_addr (ADDR_W), sram_wdata (32), outputs; sram_rdata (32), input. SRAM returns data one cycle after sram_en with !sram_we.
REQ-013 SHALL have port buf_empty, output, 1, write buffer holds zero entries.

Function
REQ-014 Stores SHALL enter a DEPTH-entry FIFO write buffer (word address + data) and retire to SRAM in order.
REQ-015 Store, buffer not full: SHALL be accepted the same cycle, stall=0.
REQ-016 Store, buffer full: SHALL assert stall; the head drains that cycle; the store is accepted the next cycle.
REQ-017 we and oe both high: SHALL be treated as a store only; rvalid=0.
REQ-018 FSM states: IDLE, RD_WAIT.
REQ-019 IDLE, load, buffer hit: SHALL return the newest matching entry combinationally, rvalid=1, stall=0, with no SRAM read.
REQ-020 IDLE, load, miss: SHALL drive sram_en=1, sram_we=0, sram_addr=word address and stall=1, then go to RD_WAIT.
REQ-021 RD_WAIT: SHALL drive d_mem_r_data=sram_rdata, rvalid=1, stall=0, then go to IDLE; a new request in RD_WAIT SHALL be held off (stall=1 only if it is not the completing load).
REQ-022 Drain: when the SRAM port is not used by a load read, a non-empty buffer SHALL pop its head with sram_en=1, sram_we=1, sram_addr and sram_wdata taken from the head.
REQ-023 Port priority SHALL be: load-miss read, then drain.
REQ-024 Enqueue and pop in the same cycle SHALL leave count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-025 Match compare SHALL use the ADDR_W-bit word address only.
REQ-026 When idle, outputs SHALL be d_mem_r_data=0, rvalid=0, sram_en=0.

Reset
REQ-027 While rst is low: state=IDLE, count=0, pointers=0, stall=0, rvalid=0, d_mem_r_data=0, sram_en=0, sram_we=0, buf_empty=1.
REQ-028 Reset asserted mid-operation SHALL discard buffered stores and any in-flight read.

Configuration
REQ-029 Macro DMEM_FWD_EN defined: load hits SHALL forward per REQ-019.
REQ-030 Macro DMEM_FWD_EN undefined: a load hit SHALL stall while draining until no entry matches, then proceed per REQ-020; no forwarding mux SHALL be present.

Verification
REQ-031 Store 0xDEADBEEF @0x10, then idle 2 cycles -> one SRAM write, addr 4, data 0xDEADBEEF; buf_empty=1.
REQ-032 Five back-to-back stores @0x0..0x10, SRAM kept busy by load misses -> fifth store stalls exactly 1 cycle; SRAM receives all five in order.
REQ-033 Store 0x11 then 0x22 @0x8, load @0x8 next cycle -> FWD: 0x22, rvalid same cycle, stall=0; no FWD: stall until drained, then 0x22.
REQ-034 Load miss @0x40 with SRAM word 16=0x1234 -> stall 1 cycle, then rvalid=1, r_data=0x1234.
REQ-035 Buffer holds 3 entries, rst low mid-drain -> all outputs at reset values; buf_empty=1; no further SRAM writes.
REQ-036 we=oe=1 @0x4 data 7 -> store enqueued, rvalid=0.
